// File: rtl/tug_ctrl.sv
// Tug-of-war reaction game controller: random dark delay, go signal, reaction
// timing, false-start detection and score-display hold, ending in a latched win.
module tug_ctrl #(
    parameter int unsigned DELAY_MIN  = 500,
    parameter int unsigned SHOW_TICKS = 1000,
    parameter int unsigned FAST_TICKS = 200,
    parameter logic [9:0]  LFSR_SEED  = 10'h2A5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       pb_l,
    input  logic       pb_r,
    input  logic [6:0] score,
    output logic [2:0] led_control,
    output logic       add_l,
    output logic       add_r,
    output logic       clr_score,
    output logic [9:0] react_cnt,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_RST,
        S_DARK,
        S_GO,
        S_SHOW,
        S_FOUL,
        S_SPEED,
        S_WIN
    } state_e;

    localparam logic [2:0]  LED_DARK   = 3'b000;
    localparam logic [2:0]  LED_RST    = 3'b001;
    localparam logic [2:0]  LED_ALL    = 3'b010;
    localparam logic [2:0]  LED_SCORE  = 3'b011;
    localparam logic [2:0]  LED_FAKE   = 3'b100;
    localparam logic [2:0]  LED_SPEED  = 3'b110;
    localparam logic [11:0] SHOW_LOAD  = 12'(SHOW_TICKS);
    localparam logic [11:0] DELAY_BASE = 12'(DELAY_MIN);
    localparam logic [9:0]  REACT_MAX  = 10'h3FF;

    state_e      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [9:0]  react_q, react_d;
    logic [9:0]  lfsr_q, lfsr_d;
    logic        pb_l_q, pb_r_q;
    logic [2:0]  led_q, led_d;
    logic        add_l_q, add_l_d;
    logic        add_r_q, add_r_d;
    logic        clr_q, clr_d;
    logic        game_over_q, game_over_d;

    logic        press_l, press_r, press_any, cnt_done, score_end, fast;
    logic [11:0] delay_load;

    assign press_l    = pb_l & ~pb_l_q;
    assign press_r    = pb_r & ~pb_r_q;
    assign press_any  = press_l | press_r;
    assign cnt_done   = (cnt_q <= 12'd1);
    assign score_end  = (score == 7'b1000000) || (score == 7'b0000001);
    assign fast       = (32'(react_q) < FAST_TICKS);
    assign delay_load = DELAY_BASE + {2'b00, lfsr_q};
    // x^10 + x^7 + 1, free-running so the delay depends on when the press lands.
    assign lfsr_d     = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        react_d = react_q;
        add_l_d = 1'b0;
        add_r_d = 1'b0;
        clr_d   = 1'b0;
        case (state_q)
            S_RST: begin
                if (press_any) begin
                    clr_d   = 1'b1;
                    cnt_d   = delay_load;
                    state_d = S_DARK;
                end
            end
            S_DARK: begin
                if (press_any) begin
                    // False start: the opponent scores; a double false start scores nobody.
                    add_l_d = press_r & ~press_l;
                    add_r_d = press_l & ~press_r;
                    cnt_d   = SHOW_LOAD;
                    state_d = S_FOUL;
                end else if (tick) begin
                    if (cnt_done) begin
                        cnt_d   = '0;
                        react_d = '0;
                        state_d = S_GO;
                    end else begin
                        cnt_d = cnt_q - 12'd1;
                    end
                end
            end
            S_GO: begin
                if (press_any) begin
                    add_l_d = press_l & ~press_r;
                    add_r_d = press_r & ~press_l;
                    cnt_d   = SHOW_LOAD;
                    state_d = (fast && (press_l ^ press_r)) ? S_SPEED : S_SHOW;
                end else if (tick && (react_q != REACT_MAX)) begin
                    react_d = react_q + 10'd1;
                end
            end
            S_SHOW, S_FOUL, S_SPEED: begin
                if (tick) begin
                    if (!cnt_done) begin
                        cnt_d = cnt_q - 12'd1;
                    end else if (score_end) begin
                        cnt_d   = '0;
                        state_d = S_WIN;
                    end else begin
                        cnt_d   = delay_load;
                        state_d = S_DARK;
                    end
                end
            end
            S_WIN: begin
                state_d = S_WIN;
            end
            default: begin
                state_d = S_RST;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered LEDs track the state register.
    always_comb begin
        led_d = LED_RST;
        case (state_d)
            S_RST:   led_d = LED_RST;
            S_DARK:  led_d = LED_DARK;
            S_GO:    led_d = LED_ALL;
            S_SHOW:  led_d = LED_SCORE;
            S_FOUL:  led_d = LED_FAKE;
            S_SPEED: led_d = LED_SPEED;
            S_WIN:   led_d = LED_SCORE;
            default: led_d = LED_RST;
        endcase
        game_over_d = (state_d == S_WIN);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_RST;
            cnt_q       <= '0;
            react_q     <= '0;
            lfsr_q      <= LFSR_SEED;
            pb_l_q      <= 1'b1;
            pb_r_q      <= 1'b1;
            led_q       <= LED_RST;
            add_l_q     <= 1'b0;
            add_r_q     <= 1'b0;
            clr_q       <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            react_q     <= react_d;
            lfsr_q      <= lfsr_d;
            pb_l_q      <= pb_l;
            pb_r_q      <= pb_r;
            led_q       <= led_d;
            add_l_q     <= add_l_d;
            add_r_q     <= add_r_d;
            clr_q       <= clr_d;
            game_over_q <= game_over_d;
        end
    end

    assign led_control = led_q;
    assign add_l       = add_l_q;
    assign add_r       = add_r_q;
    assign clr_score   = clr_q;
    assign react_cnt   = react_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_tug_ctrl.sv
// Directed bench for tug_ctrl: a vector table for the first presses, then
// hand-written rounds covering fouls, fast/slow wins, ties, reset and the win latch.
module tb_tug_ctrl;

    localparam logic [9:0] SEED   = 10'h2A5;
    localparam logic [6:0] CENTER = 7'b0001000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       pb_l;
    logic       pb_r;
    logic [6:0] score;
    logic [2:0] led_control;
    logic       add_l;
    logic       add_r;
    logic       clr_score;
    logic [9:0] react_cnt;
    logic       game_over;

    always #5 clk = ~clk;

    tug_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .pb_l       (pb_l),
        .pb_r       (pb_r),
        .score      (score),
        .led_control(led_control),
        .add_l      (add_l),
        .add_r      (add_r),
        .clr_score  (clr_score),
        .react_cnt  (react_cnt),
        .game_over  (game_over)
    );

    typedef struct {
        logic       l;
        logic       r;
        logic       t;
        logic [2:0] led;
        logic       al;
        logic       ar;
        logic       clr;
        logic       go;
    } vec_t;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_add_l  = 0;
    int         n_add_r  = 0;
    int         n_multi  = 0;
    logic [9:0] m_lfsr   = SEED;
    logic [9:0] last_lfsr;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One clock: inputs driven here, the LFSR model follows the DUT's edge, outputs read at negedge.
    task automatic cyc(input logic l, input logic r, input logic t);
        pb_l = l;
        pb_r = r;
        tick = t;
        last_lfsr = m_lfsr;
        @(posedge clk);
        m_lfsr = rst_n ? {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]} : SEED;
        @(negedge clk);
        n_add_l += int'(add_l);
        n_add_r += int'(add_r);
        if (int'(add_l) + int'(add_r) + int'(clr_score) > 1) n_multi++;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
    endtask

    // Tick every `period` cycles until the LEDs show `want` (or game_over rises), counting ticks.
    task automatic run_until(input logic [2:0] want, input bit want_win, input int period,
                             input string name, output int ticks);
        int   cycles;
        logic t;
        cycles = 0;
        ticks  = 0;
        while (!(want_win ? game_over : (led_control == want)) && cycles < 6000) begin
            t = ((cycles % period) == 0);
            cyc(1'b0, 1'b0, t);
            ticks += int'(t);
            cycles++;
        end
        if (want_win) check(name, int'(game_over), 1);
        else check(name, int'(led_control), int'(want));
    endtask

    vec_t vecs[6];
    int   d_exp;
    int   ticks;
    int   al0, ar0;

    initial begin
        rst_n = 1'b0;
        pb_l  = 1'b0;
        pb_r  = 1'b0;
        tick  = 1'b0;
        score = CENTER;
        d_exp = 0;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        check("rst led", int'(led_control), 3'b001);
        check("rst add_l", int'(add_l), 0);
        check("rst add_r", int'(add_r), 0);
        check("rst clr", int'(clr_score), 0);
        check("rst react", int'(react_cnt), 0);
        check("rst game_over", int'(game_over), 0);
        rst_n = 1'b1;

        // Table: idle in RST, start press, held level, DARK ticks
        for (int i = 0; i < 6; i++) begin
            cyc(vecs[i].l, vecs[i].r, vecs[i].t);
            if (i == 2) d_exp = 500 + int'(last_lfsr);
            check($sformatf("vec%0d led", i), int'(led_control), int'(vecs[i].led));
            check($sformatf("vec%0d add_l", i), int'(add_l), int'(vecs[i].al));
            check($sformatf("vec%0d add_r", i), int'(add_r), int'(vecs[i].ar));
            check($sformatf("vec%0d clr", i), int'(clr_score), int'(vecs[i].clr));
            check($sformatf("vec%0d game_over", i), int'(game_over), int'(vecs[i].go));
        end

        // Round 1: fast left win at 150 ticks -> SPEED
        run_until(3'b010, 1'b0, 1, "r1 reach GO", ticks);
        check("r1 dark ticks", ticks, d_exp - 2);
        check("r1 react cleared", int'(react_cnt), 0);
        run_ticks(150);
        check("r1 react 150", int'(react_cnt), 150);
        al0 = n_add_l; ar0 = n_add_r;
        cyc(1'b1, 1'b0, 1'b1);
        check("r1 add_l pulse", int'(add_l), 1);
        check("r1 add_r quiet", int'(add_r), 0);
        check("r1 speed led", int'(led_control), 3'b110);
        check("r1 react kept", int'(react_cnt), 150);
        cyc(1'b0, 1'b0, 1'b1);
        check("r1 add_l one cycle", int'(add_l), 0);
        run_until(3'b000, 1'b0, 1, "r1 back to DARK", ticks);
        check("r1 speed ticks", ticks + 1, 1000);
        check("r1 add_l count", n_add_l - al0, 1);
        check("r1 add_r count", n_add_r - ar0, 0);
        d_exp = 500 + int'(last_lfsr);

        // Round 2: right false start 100 ticks into DARK -> add_l, FOUL
        run_ticks(100);
        check("r2 still dark", int'(led_control), 3'b000);
        al0 = n_add_l; ar0 = n_add_r;
        cyc(1'b0, 1'b1, 1'b1);
        check("r2 foul add_l", int'(add_l), 1);
        check("r2 foul add_r", int'(add_r), 0);
        check("r2 foul led", int'(led_control), 3'b100);
        run_until(3'b000, 1'b0, 1, "r2 back to DARK", ticks);
        check("r2 foul ticks", ticks, 1000);
        check("r2 add_l count", n_add_l - al0, 1);
        check("r2 add_r count", n_add_r - ar0, 0);
        d_exp = 500 + int'(last_lfsr);

        // Round 3: sparse ticks in DARK, then a tie in GO -> SHOW, no point
        run_until(3'b010, 1'b0, 3, "r3 reach GO", ticks);
        check("r3 dark ticks sparse", ticks, d_exp);
        run_ticks(300);
        al0 = n_add_l; ar0 = n_add_r;
        cyc(1'b1, 1'b1, 1'b1);
        check("r3 tie led", int'(led_control), 3'b011);
        check("r3 tie react", int'(react_cnt), 300);
        run_until(3'b000, 1'b0, 1, "r3 back to DARK", ticks);
        check("r3 show ticks", ticks, 1000);
        check("r3 no adds", (n_add_l - al0) + (n_add_r - ar0), 0);
        d_exp = 500 + int'(last_lfsr);

        // Round 4: slow right win -> SHOW, ignored presses, score at edge -> WIN
        run_until(3'b010, 1'b0, 1, "r4 reach GO", ticks);
        check("r4 dark ticks", ticks, d_exp);
        run_ticks(250);
        cyc(1'b0, 1'b1, 1'b0);
        check("r4 add_r pulse", int'(add_r), 1);
        check("r4 add_l quiet", int'(add_l), 0);
        check("r4 show led", int'(led_control), 3'b011);
        run_ticks(100);
        al0 = n_add_l; ar0 = n_add_r;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        check("r4 show ignores presses", (n_add_l - al0) + (n_add_r - ar0), 0);
        check("r4 show led held", int'(led_control), 3'b011);
        score = 7'b1000000;
        run_until(3'b011, 1'b1, 1, "r4 reach WIN", ticks);
        check("r4 show ticks left", ticks, 900);
        check("r4 win led", int'(led_control), 3'b011);
        al0 = n_add_l; ar0 = n_add_r;
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        run_ticks(50);
        check("r4 win ignores presses", (n_add_l - al0) + (n_add_r - ar0), 0);
        check("r4 win led held", int'(led_control), 3'b011);
        check("r4 win latched", int'(game_over), 1);
        check("r4 react held", int'(react_cnt), 250);
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        check("r4 reset led", int'(led_control), 3'b001);
        check("r4 reset game_over", int'(game_over), 0);
        check("r4 reset react", int'(react_cnt), 0);
        score = CENTER;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);

        // Round 5: reset mid-DARK with pb_l held; needs release and a fresh press
        cyc(1'b1, 1'b0, 1'b0);
        check("r5 start clr", int'(clr_score), 1);
        check("r5 start led", int'(led_control), 3'b000);
        al0 = n_add_l; ar0 = n_add_r;
        repeat (20) cyc(1'b1, 1'b0, 1'b1);
        check("r5 held no foul", (n_add_l - al0) + (n_add_r - ar0), 0);
        check("r5 held dark", int'(led_control), 3'b000);
        rst_n = 1'b0;
        repeat (2) cyc(1'b1, 1'b0, 1'b1);
        check("r5 reset led", int'(led_control), 3'b001);
        rst_n = 1'b1;
        repeat (5) cyc(1'b1, 1'b0, 1'b1);
        check("r5 held after reset led", int'(led_control), 3'b001);
        check("r5 held after reset clr", int'(clr_score), 0);
        cyc(1'b0, 1'b0, 1'b1);
        check("r5 released led", int'(led_control), 3'b001);
        cyc(1'b1, 1'b0, 1'b1);
        check("r5 repress clr", int'(clr_score), 1);
        check("r5 repress led", int'(led_control), 3'b000);
        d_exp = 500 + int'(last_lfsr);

        // Round 6: react_cnt saturation, then left-end score -> WIN
        run_until(3'b010, 1'b0, 1, "r6 reach GO", ticks);
        check("r6 dark ticks", ticks, d_exp);
        run_ticks(1100);
        check("r6 react saturated", int'(react_cnt), 1023);
        cyc(1'b1, 1'b0, 1'b1);
        check("r6 add_l pulse", int'(add_l), 1);
        check("r6 slow show led", int'(led_control), 3'b011);
        score = 7'b0000001;
        run_until(3'b011, 1'b1, 1, "r6 reach WIN", ticks);
        check("r6 show ticks", ticks, 1000);
        check("r6 react final", int'(react_cnt), 1023);

        check("single pulse per cycle", n_multi, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tug_ctrl.md
TUG_CTRL -- requirements
Module: tug_ctrl

Interface
REQ-001 Parameter DELAY_MIN, default 500: minimum dark time in ticks before the go signal.
REQ-002 Parameter SHOW_TICKS, default 1000: score-display hold time in ticks.
REQ-003 Parameter FAST_TICKS, default 200: reaction time in ticks below which the speed display is shown.
REQ-004 Parameter LFSR_SEED, default 10'h2A5: non-zero LFSR reset value.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 tick  input  1  one-cycle 1 ms enable pulse; all timers count only on tick.
REQ-008 pb_l, pb_r  input  1 each  synchronized, debounced button levels for the left and right players.
REQ-009 score  input  7  current one-hot rope position from the scorer.
REQ-010 led_control  output  3  LED mux select: 000 dark, 001 reset code, 010 all on, 011 score, 100 fake score, 110 speed.
REQ-011 add_l, add_r  output  1 each  one-cycle pulses that move the rope one step toward the left or right player.
REQ-012 clr_score  output  1  one-cycle pulse that re-centres the scorer.
REQ-013 react_cnt  output  10  reaction time of the last won round in ticks, saturating at 1023.
REQ-014 game_over  output  1  high while in WIN.

Function
REQ-015 Rising-edge detection is internal; a press is pb_x high this cycle and low the previous cycle; held levels never retrigger.
REQ-016 10-bit LFSR, taps x^10+x^7+1, advances every clk, including when tick is low.
REQ-017 States and led_control: RST=001, DARK=000, GO=010, SHOW=011, FOUL=100, SPEED=110, WIN=011.
REQ-018 RST: on a press of either button, pulse clr_score for one cycle, load the delay counter with DELAY_MIN + lfsr (12-bit, no overflow), and go to DARK.
REQ-019 DARK: decrement on tick; on reaching 0, clear react_cnt and go to GO.
REQ-020 DARK press (false start): pulse the opponent's add for one cycle, load SHOW_TICKS, and go to FOUL; a simultaneous press by both players gives no point and goes to FOUL.
REQ-021 GO: increment react_cnt on tick, saturating at 1023; on the first press, pulse the presser's add (left press -> add_l) and load SHOW_TICKS; go to SPEED if react_cnt < FAST_TICKS, else go to SHOW.
REQ-022 GO, both players press in the same cycle: no add pulse, load SHOW_TICKS, go to SHOW.
REQ-023 GO has no timeout; it waits indefinitely.
REQ-024 SHOW, FOUL, SPEED: decrement on tick and ignore all presses; at 0, evaluate the exit condition.
REQ-025 Exit condition: if score == 7'b1000000 or 7'b0000001, go to WIN; otherwise reload DELAY_MIN + lfsr and go to DARK.
REQ-026 The exit condition samples score in the cycle the hold counter reaches 0; the scorer updates within 1 cycle of an add pulse.
REQ-027 WIN: game_over = 1 and led_control = 011; ignore presses; leave only via rst_n.
REQ-028 At most one of add_l, add_r, and clr_score is high in any cycle.
REQ-029 All outputs are registered; led_control changes in the cycle after the state change.
REQ-030 tick coincident with a press: press handling takes priority, and that tick is not counted.

Reset
REQ-031 When rst_n = 0 at a clk edge, the block enters RST regardless of current state, including mid-timer.
REQ-032 Reset values: led_control = 001, add_l = add_r = clr_score = 0, react_cnt = 0, game_over = 0, counters = 0, LFSR = LFSR_SEED, edge-detect registers = 1 (a button held through reset is not a press).

Verification
REQ-033 Reset, then press pb_l -> clr_score pulses 1 cycle; led_control 001 -> 000; delay = 500 + lfsr value sampled at press.
REQ-034 pb_r pressed 100 ticks into DARK -> add_l pulses once; led_control = 100 for 1000 ticks; then 000.
REQ-035 Reaching GO, pb_l pressed at tick 150 -> add_l pulses; react_cnt = 150; led_control = 110 for 1000 ticks; then 000.
REQ-036 In GO, pb_l and pb_r pressed in the same cycle -> no add pulse; led_control = 011 for 1000 ticks.
REQ-037 score forced to 7'b1000000 during SHOW -> at timeout, led_control = 011 and game_over = 1; further presses have no effect; rst_n low -> led_control = 001.
REQ-038 rst_n asserted mid-DARK with pb_l held high -> RST entered; no transition until pb_l is released and pressed again.
